rddata_collector: RTL
=====================

// Module: rddata_collector
// PURPOSE
//   Return-path counterpart of the instruction dispatcher: gathers DFI read-data beats into
//   8*DQ_WIDTH-bit burst words and queues them for the host read-back FIFO.
//   Keeps an in-order tag queue of issued reads; periodic-read bursts are consumed and dropped,
//   host bursts are forwarded. Sits between the PHY DFI read port and the host read-back FIFO.
// PARAMETERS
//   DQ_WIDTH   64  DRAM data width; one DFI beat = 4*DQ_WIDTH bits, one burst = 2 beats
//   TAG_DEPTH  8   outstanding-read tag queue depth (power of 2, >=2)
// PORTS
//   clk                input   1            clock
//   rst_n              input   1            asynchronous active-low reset
//   rd_issue           input   1            pulse: read command dispatched this cycle
//   rd_issue_periodic  input   1            qualifies rd_issue: 1 = periodic read (drop data)
//   dfi_rddata_valid   input   1            DFI read beat valid (cannot be stalled)
//   dfi_rddata         input   4*DQ_WIDTH   DFI read beat
//   rdback_valid       output  1            burst word available
//   rdback_data        output  8*DQ_WIDTH   burst word {beat1, beat0}
//   rdback_ready       input   1            host FIFO accepts word (pop when valid&ready)
//   pr_rd_done         output  1            1-cycle pulse: periodic burst completed and dropped
//   outstanding        output  $clog2(TAG_DEPTH)+1  tags queued, not yet completed
//   err_clr            input   1            clears sticky error flags
//   err_tag_ovf        output  1            sticky: rd_issue while tag queue full
//   err_orphan         output  1            sticky: beat arrived with tag queue empty
//   err_rdback_ovf     output  1            sticky: host burst completed with output buffer full
// BEHAVIOUR
// - Reset: all outputs 0, tag queue and output buffer empty, FSM in EXP_LO, counters 0.
// - Tag queue: rd_issue pushes rd_issue_periodic. Pop on completion of second beat.
//   Push+pop same cycle allowed at any level (incl. full: pop frees slot, push accepted).
//   Push when full without pop: tag dropped, err_tag_ovf set.
// - FSM: EXP_LO --valid & tag present--> EXP_HI (beat0 captured into low half).
//   EXP_HI --valid--> EXP_LO (beat1 into high half; burst complete, tag popped).
//   Gaps between beats allowed; no timeout.
//   Beat in EXP_LO with empty queue: beat discarded, err_orphan set, state unchanged.
// - Completion, tag=periodic: pr_rd_done pulses the cycle after the second beat. No push.
// - Completion, tag=host: word pushed into 2-entry output buffer. rdback_valid is high the
//   cycle after the second beat (1-cycle latency, registered outputs).
// - Output buffer push when full is accepted only if a pop occurs the same cycle. Otherwise
//   the word is dropped and err_rdback_ovf set. rdback_data is stable while valid & !ready.
// - err_clr clears all sticky flags; a same-cycle error event wins (flag stays set).
// - outstanding = tag count; updated the cycle after push/pop.
// - Reset mid-burst: partial beat discarded; tags and buffered words lost.
// CONFIGURATION
//   RDDATA_COLLECTOR_STATS_EN defined: adds outputs stat_host_bursts[15:0] and
//     stat_pr_bursts[15:0]. Each is a saturating count of completed host / periodic bursts,
//     cleared by err_clr.
//   Not defined: ports absent, no counter logic.
// STRUCTURE
//   Shared package: beat/burst width functions of DQ_WIDTH, FSM state enum {EXP_LO, EXP_HI},
//   tag encoding constants (TAG_HOST=0, TAG_PR=1).
//   One sub-module: rdc_tag_fifo (TAG_DEPTH x 1-bit sync FIFO with count and
//   simultaneous push/pop). The output buffer is inline, 2 entries.
// TESTING
// 1. rd_issue(host), beats A then B on consecutive cycles -> next cycle rdback_valid=1,
//    data={B,A}; outstanding 1->0.
// 2. rd_issue(periodic), two beats -> pr_rd_done single pulse, rdback_valid stays 0.
// 3. Three host reads, rdback_ready=0 -> 2 words held. Third sets err_rdback_ovf.
//    Raise ready -> first two words emerge in order.
// 4. Beat with no tag issued -> err_orphan=1, no output. err_clr -> flag 0.
// 5. 9 rd_issue with TAG_DEPTH=8 and no data -> err_tag_ovf=1, outstanding=8.
//    Issue + completion same cycle at full -> outstanding stays 8, no error.
// 6. Assert rst_n low between beat0 and beat1 -> outputs 0. The next full burst is assembled
//    cleanly from new beats.

Source files
------------

// File: rtl/rddata_collector_pkg.sv
// Shared definitions for the DFI read-data collector: beat/burst widths,
// FSM state encoding and tag encoding of the outstanding-read queue.
package rddata_collector_pkg;

   // Beat-assembly state: waiting for the low (first) or high (second) beat.
   typedef enum logic [0:0] {
      EXP_LO = 1'b0,
      EXP_HI = 1'b1
   } rdc_state_e;

   // Tag values stored per issued read.
   localparam logic TAG_HOST = 1'b0;
   localparam logic TAG_PR   = 1'b1;

   // One DFI beat carries four DRAM data transfers.
   function automatic int unsigned beat_width(input int unsigned dq);
      return 32'd4 * dq;
   endfunction

   // One burst word is two beats.
   function automatic int unsigned burst_width(input int unsigned dq);
      return 32'd8 * dq;
   endfunction

endpackage

// File: rtl/rddata_collector_tag_fifo.sv
// rdc_tag_fifo: DEPTH x 1-bit synchronous FIFO holding the tags of issued
// reads in order. A push is accepted when not full, or when full together
// with a pop (the pop frees the slot). Pops on an empty FIFO are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module rdc_tag_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     push_data_i,
   input  logic                     pop_i,
   output logic                     pop_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [PW:0]      count_q;
   logic             full_s;
   logic             empty_s;
   logic             pop_ok_s;
   logic             push_ok_s;

   assign full_s    = (count_q == CNT_FULL);
   assign empty_s   = (count_q == '0);
   assign pop_ok_s  = pop_i & ~empty_s;
   assign push_ok_s = push_i & (~full_s | pop_ok_s);

   assign pop_data_o = mem_q[rptr_q];
   assign count_o    = count_q;
   assign full_o     = full_s;
   assign empty_o    = empty_s;

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok_s) begin
            mem_q[wptr_q] <= push_data_i;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop_ok_s) begin
            rptr_q <= rptr_q + 1'b1;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/rddata_collector.sv
// rddata_collector: assembles pairs of DFI read beats into burst words,
// matches each burst to the oldest issued-read tag, drops periodic-read
// bursts (pulsing pr_rd_done) and queues host bursts in a 2-entry output
// buffer towards the host read-back FIFO.
// Optional feature macro: RDDATA_COLLECTOR_STATS_EN adds saturating
// per-kind burst counters (stat_host_bursts, stat_pr_bursts).
module rddata_collector
   import rddata_collector_pkg::*;
#(
   parameter int unsigned DQ_WIDTH  = 64,
   parameter int unsigned TAG_DEPTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 rd_issue,
   input  logic                                 rd_issue_periodic,
   input  logic                                 dfi_rddata_valid,
   input  logic [beat_width(DQ_WIDTH)-1:0]      dfi_rddata,
   output logic                                 rdback_valid,
   output logic [burst_width(DQ_WIDTH)-1:0]     rdback_data,
   input  logic                                 rdback_ready,
   output logic                                 pr_rd_done,
   output logic [$clog2(TAG_DEPTH):0]           outstanding,
   input  logic                                 err_clr,
   output logic                                 err_tag_ovf,
   output logic                                 err_orphan,
   output logic                                 err_rdback_ovf
`ifdef RDDATA_COLLECTOR_STATS_EN
   ,
   output logic [15:0]                          stat_host_bursts,
   output logic [15:0]                          stat_pr_bursts
`endif
);

   localparam int unsigned BEAT_W = beat_width(DQ_WIDTH);
   localparam int unsigned WORD_W = burst_width(DQ_WIDTH);

   rdc_state_e          state_q;
   logic [BEAT_W-1:0]   lo_q;
   logic                pr_done_q;
   logic                err_tag_ovf_q;
   logic                err_orphan_q;
   logic                err_rdback_ovf_q;
   logic [WORD_W-1:0]   head_q, head_d;
   logic [WORD_W-1:0]   tail_q, tail_d;
   logic                v0_q, v0_d;
   logic                v1_q, v1_d;

   logic                tag_head_s;
   logic                tag_full_s;
   logic                tag_empty_s;
   logic                complete_s;
   logic                orphan_s;
   logic                tag_ovf_s;
   logic                host_done_s;
   logic                pr_done_s;
   logic                rb_pop_s;
   logic                rb_ovf_s;
   logic [WORD_W-1:0]   word_s;

   // A burst completes on the second beat; that same cycle retires its tag.
   assign complete_s  = dfi_rddata_valid & (state_q == EXP_HI);
   assign orphan_s    = dfi_rddata_valid & (state_q == EXP_LO) & tag_empty_s;
   assign tag_ovf_s   = rd_issue & tag_full_s & ~complete_s;
   assign host_done_s = complete_s & (tag_head_s == TAG_HOST);
   assign pr_done_s   = complete_s & (tag_head_s == TAG_PR);
   assign rb_pop_s    = v0_q & rdback_ready;
   assign word_s      = {dfi_rddata, lo_q};

   rdc_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (rd_issue),
      .push_data_i (rd_issue_periodic),
      .pop_i       (complete_s),
      .pop_data_o  (tag_head_s),
      .count_o     (outstanding),
      .full_o      (tag_full_s),
      .empty_o     (tag_empty_s)
   );

   // Beat-assembly FSM: capture beat0 when a tag is waiting, finish on beat1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EXP_LO;
         lo_q    <= '0;
      end else begin
         case (state_q)
            EXP_LO: begin
               if (dfi_rddata_valid && !tag_empty_s) begin
                  lo_q    <= dfi_rddata;
                  state_q <= EXP_HI;
               end
            end
            EXP_HI: begin
               if (dfi_rddata_valid) begin
                  state_q <= EXP_LO;
               end
            end
            default: state_q <= EXP_LO;
         endcase
      end
   end

   // Output buffer next state: pop shifts the tail forward, then a new word
   // lands in the first free slot; no free slot means the word is lost.
   always_comb begin
      head_d   = rb_pop_s ? tail_q : head_q;
      v0_d     = rb_pop_s ? v1_q   : v0_q;
      v1_d     = rb_pop_s ? 1'b0   : v1_q;
      tail_d   = tail_q;
      rb_ovf_s = 1'b0;
      if (host_done_s) begin
         if (!v0_d) begin
            head_d = word_s;
            v0_d   = 1'b1;
         end else if (!v1_d) begin
            tail_d = word_s;
            v1_d   = 1'b1;
         end else begin
            rb_ovf_s = 1'b1;
         end
      end else begin
         rb_ovf_s = 1'b0;
      end
   end

   // Output buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         v0_q   <= 1'b0;
         v1_q   <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         v0_q   <= v0_d;
         v1_q   <= v1_d;
      end
   end

   // Completion pulse and sticky error flags; a new event beats err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr_done_q        <= 1'b0;
         err_tag_ovf_q    <= 1'b0;
         err_orphan_q     <= 1'b0;
         err_rdback_ovf_q <= 1'b0;
      end else begin
         pr_done_q        <= pr_done_s;
         err_tag_ovf_q    <= tag_ovf_s | (err_tag_ovf_q & ~err_clr);
         err_orphan_q     <= orphan_s  | (err_orphan_q & ~err_clr);
         err_rdback_ovf_q <= rb_ovf_s  | (err_rdback_ovf_q & ~err_clr);
      end
   end

   assign rdback_valid   = v0_q;
   assign rdback_data    = head_q;
   assign pr_rd_done     = pr_done_q;
   assign err_tag_ovf    = err_tag_ovf_q;
   assign err_orphan     = err_orphan_q;
   assign err_rdback_ovf = err_rdback_ovf_q;

`ifdef RDDATA_COLLECTOR_STATS_EN
   logic [15:0] stat_host_q;
   logic [15:0] stat_pr_q;

   // Saturating completed-burst counters, cleared together with the flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_host_q <= 16'd0;
         stat_pr_q   <= 16'd0;
      end else if (err_clr) begin
         stat_host_q <= 16'd0;
         stat_pr_q   <= 16'd0;
      end else begin
         if (host_done_s && (stat_host_q != 16'hFFFF)) begin
            stat_host_q <= stat_host_q + 16'd1;
         end
         if (pr_done_s && (stat_pr_q != 16'hFFFF)) begin
            stat_pr_q <= stat_pr_q + 16'd1;
         end
      end
   end

   assign stat_host_bursts = stat_host_q;
   assign stat_pr_bursts   = stat_pr_q;
`endif

endmodule
